// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-port register file.
//   state_e      - CLEAR (post-reset zeroing sweep) / RUN (normal operation)
//   DEF_DATA_W   - default register width
//   DEF_ADDR_W   - default address width (DEPTH = 2**ADDR_W)
//   lsb()        - low bit index of slice `idx` in a flattened port bus
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    function automatic int unsigned lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_sweep.sv
// regfile_sweep: CLEAR/RUN controller for the post-reset clearing sweep.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (forces CLEAR, counter 0)
//   ready      out  high in RUN, once every entry has been zeroed
//   sweep_we   out  zero-write enable for entry sweep_addr (CLEAR only)
//   sweep_addr out  entry being cleared this cycle
module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                // Counter holds at the last entry rather than wrapping.
                if (cnt_q == LAST) state_d = RUN;
                else               cnt_d   = cnt_q + ADDR_W'(1);
            end
            RUN:     ;
            default: state_d = CLEAR;
        endcase
    end

    assign ready      = (state_q == RUN);
    assign sweep_we   = (state_q == CLEAR) && !rst;
    assign sweep_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with busy scoreboard and
// post-reset clearing sweep.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ra  / rd / rbusy NUM_RD async read ports (addr, data, busy bit)
//   we  / wa / wd    NUM_WR sync write ports; highest port index wins on collision
//   set_busy, busy_addr  mark an entry pending; beats a same-edge write clear
//   ready            high once the clearing sweep has finished
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding of
// same-cycle write data onto the read ports (default: read-before-write).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    input  logic [NUM_WR*DATA_W-1:0] wd,
    input  logic                     set_busy,
    input  logic [ADDR_W-1:0]        busy_addr,
    output logic                     ready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [NUM_WR-1:0] wr_ok;
    logic              set_ok;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;
`ifdef REGFILE_BYPASS_EN
    logic              rd_hit;
`endif

    regfile_sweep #(.ADDR_W(ADDR_W)) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Qualified write/set strobes: RUN only, never during reset, and never
    // to the hardwired zero entry.
    always_comb begin
        wr_ok = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            wr_ok[j] = ready && !rst && we[j] &&
                       !(ZERO_REG != 0 && wa[lsb(j, ADDR_W) +: ADDR_W] == '0);
        end
        set_ok = ready && !rst && set_busy &&
                 !(ZERO_REG != 0 && busy_addr == '0);
    end

    // Ascending port order makes the highest enabled port win; set_busy is
    // applied last so a new producer overrides a same-edge clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (sweep_we) mem_d[sweep_addr] = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) begin
                mem_d[wa[lsb(j, ADDR_W) +: ADDR_W]]  = wd[lsb(j, DATA_W) +: DATA_W];
                busy_d[wa[lsb(j, ADDR_W) +: ADDR_W]] = 1'b0;
            end
        end
        if (set_ok) busy_d[busy_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        rd      = '0;
        rbusy   = '0;
        rd_addr = '0;
        rd_data = '0;
        rd_busy = 1'b0;
`ifdef REGFILE_BYPASS_EN
        rd_hit  = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_addr = ra[lsb(i, ADDR_W) +: ADDR_W];
            rd_data = mem_q[rd_addr];
            rd_busy = busy_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            rd_hit  = 1'b0;
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j] && wa[lsb(j, ADDR_W) +: ADDR_W] == rd_addr) begin
                    rd_data = wd[lsb(j, DATA_W) +: DATA_W];
                    rd_hit  = 1'b1;
                end
            end
            if (rd_hit) rd_busy = set_ok && (busy_addr == rd_addr);
`endif
            if ((ZERO_REG != 0 && rd_addr == '0) || !ready) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
            rd[lsb(i, DATA_W) +: DATA_W] = rd_data;
            rbusy[i]                     = rd_busy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*AW-1:0] ra;
    logic [2*DW-1:0] rd;
    logic [1:0]      rbusy;
    logic [1:0]      we;
    logic [2*AW-1:0] wa;
    logic [2*DW-1:0] wd;
    logic            set_busy;
    logic [AW-1:0]   busy_addr;
    logic            ready;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (2),
        .NUM_WR   (2),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ra        (ra),
        .rd        (rd),
        .rbusy     (rbusy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .set_busy  (set_busy),
        .busy_addr (busy_addr),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we       = '0;
        set_busy = 1'b0;
    endtask

    // Pulse reset, then expect ready low for 31 edges and high on the 32nd.
    // Writes/set_busy are held active at entry 20 the whole time: must be ignored.
    task automatic reset_sweep(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({tag, "_rst_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_rst_rd"}, rd[DW-1:0], 32'd0);
        check({tag, "_rst_rbusy"}, {30'd0, rbusy}, 32'd0);
        we = 2'b11; wa = {5'd20, 5'd20}; wd = {32'h5555_5555, 32'h4444_4444};
        set_busy = 1'b1; busy_addr = 5'd20;
        for (int i = 1; i <= 32; i++) begin
            if (i == 32) idle();
            tick();
            if (i == 31 || i == 32)
                check($sformatf("%s_ready_e%0d", tag, i), {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
            else if (ready !== 1'b0)
                check($sformatf("%s_ready_e%0d", tag, i), {31'd0, ready}, 32'd0);
        end
        idle();
    endtask

    initial begin
        rst = 1'b0; ra = '0; we = '0; wa = '0; wd = '0;
        set_busy = 1'b0; busy_addr = '0;

        reset_sweep("init");
        ra = {5'd20, 5'd7};
        #1;
        check("init_rd7", rd[DW-1:0], 32'd0);
        check("clear_ignores_write", rd[2*DW-1:DW], 32'd0);
        check("clear_ignores_busy", {31'd0, rbusy[1]}, 32'd0);

        // Preload entry 7, then reset sweep must zero it.
        we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'hDEAD_BEEF};
        tick(); idle();
        check("preload_rd7", rd[DW-1:0], 32'hDEAD_BEEF);
        // Busy on entry 10 must be cleared by reset.
        set_busy = 1'b1; busy_addr = 5'd10;
        tick(); idle();
        ra = {5'd10, 5'd7};
        #1;
        check("busy10_set", {31'd0, rbusy[1]}, 32'd1);
        reset_sweep("sweep");
        ra = {5'd10, 5'd7};
        #1;
        check("sweep_rd7", rd[DW-1:0], 32'd0);
        check("sweep_busy10", {31'd0, rbusy[1]}, 32'd0);

        // Reset mid-sweep restarts the full 32-edge count.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset_sweep("midclr");

        // Dual write, distinct addresses.
        we = 2'b11; wa = {5'd4, 5'd3}; wd = {32'h22, 32'h11};
        tick(); idle();
        ra = {5'd4, 5'd3};
        #1;
        check("dual_rd3", rd[DW-1:0], 32'h11);
        check("dual_rd4", rd[2*DW-1:DW], 32'h22);

        // Collision: port 1 wins.
        we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'hBBBB, 32'hAAAA};
        tick(); idle();
        ra = {5'd5, 5'd5};
        #1;
        check("collide_rd5", rd[DW-1:0], 32'hBBBB);

        // Zero register.
        we = 2'b10; wa = {5'd0, 5'd0}; wd = {32'hFFFF_FFFF, 32'd0};
        set_busy = 1'b1; busy_addr = 5'd0;
        tick(); idle();
        ra = {5'd0, 5'd0};
        #1;
        check("zero_rd", rd[DW-1:0], 32'd0);
        check("zero_rbusy", {30'd0, rbusy}, 32'd0);

        // Scoreboard.
        ra = {5'd3, 5'd9};
        set_busy = 1'b1; busy_addr = 5'd9;
        tick(); idle();
        check("sb_set", {31'd0, rbusy[0]}, 32'd1);
        check("sb_other", {31'd0, rbusy[1]}, 32'd0);
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h77};
        set_busy = 1'b1; busy_addr = 5'd9;
        tick(); idle();
        check("sb_set_wins", {31'd0, rbusy[0]}, 32'd1);
        check("sb_set_wins_data", rd[DW-1:0], 32'h77);
        we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h99, 32'd0};
        tick(); idle();
        check("sb_clear", {31'd0, rbusy[0]}, 32'd0);
        check("sb_clear_data", rd[DW-1:0], 32'h99);

        // Same-cycle read of a write target.
        ra = {5'd0, 5'd12};
        we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'd0, 32'h1234};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same_cycle", rd[DW-1:0], 32'h1234);
`else
        check("byp_same_cycle", rd[DW-1:0], 32'd0);
`endif
        tick(); idle();
        check("byp_next_cycle", rd[DW-1:0], 32'h1234);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the single-write 32x32 CPU register file. Adds configurable data width, depth, read-port and write-port counts, a per-entry busy scoreboard for long-latency producers (mult/div, loads), and a post-reset clearing sweep. It sits in the decode stage of the pipeline, feeding operands and hazard status to issue logic.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of asynchronous read ports
- NUM_WR, 2, number of synchronous write ports
- ZERO_REG, 1, when 1 entry 0 reads as zero and ignores writes
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rbusy  out  NUM_RD  busy bit of entry ra[i]
- we  in  NUM_WR  write enables
- wa  in  NUM_WR*ADDR_W  write addresses
- wd  in  NUM_WR*DATA_W  write data
- set_busy  in  1  mark entry busy_addr as pending
- busy_addr  in  ADDR_W  entry to mark busy
- ready  out  1  high once the clearing sweep is complete

## Operation
- FSM states: CLEAR, RUN. rst forces CLEAR with sweep counter = 0 and clears all busy bits in the same edge.
- CLEAR: each edge writes 0 to entry[counter], counter++; on counter == DEPTH-1 go to RUN. All we and set_busy inputs are ignored; rd forced to 0, rbusy forced to 0.
- RUN: for each write port j with we[j], entry[wa[j]] <= wd[j] and busy[wa[j]] <= 0.
- Same address on several enabled write ports: highest port index wins.
- ZERO_REG=1: writes and set_busy to address 0 are dropped; rd for address 0 is 0, rbusy for address 0 is 0.
- set_busy in RUN: busy[busy_addr] <= 1. Same edge as a write clearing that address: set wins (new producer issued).
- rst asserted mid-CLEAR or mid-RUN: sweep restarts from entry 0; ready drops next edge.
- Counter width ADDR_W; no wrap beyond DEPTH-1.

## Timing
- Reset values: ready = 0, rd = 0, rbusy = 0, state = CLEAR, counter = 0.
- ready rises after exactly DEPTH rising edges with rst low (first such edge clears entry 0).
- Reads combinational from ra; no added latency.
- Writes visible to reads the cycle after the write edge (default) — see Configuration.
- Busy set/clear visible on rbusy the cycle after the edge.

## Configuration
- REGFILE_BYPASS_EN defined: write-first forwarding. In RUN, a read port whose ra matches an enabled wa returns that wd (highest matching port index) in the same cycle, and rbusy reads 0 for that address unless set_busy targets it that cycle. Address 0 under ZERO_REG is never forwarded.
- Undefined: read-before-write; rd/rbusy reflect stored state only.

## Structure
- Package regfile_pkg: state enum (CLEAR, RUN), default DATA_W/ADDR_W constants, port-slice helper functions.
- Sub-module regfile_sweep: CLEAR/RUN FSM and sweep counter, outputs ready, sweep_we, sweep_addr.
- Storage, busy vector, write-priority and bypass mux in regfile_mp.

## Test plan
- Reset sweep: preload entry 7 = 0xDEADBEEF, pulse rst 1 cycle -> ready low for 32 cycles, then high; rd for ra=7 is 0x00000000.
- Dual write, distinct addresses: we=2'b11, wa0=3/wd0=0x11, wa1=4/wd1=0x22 -> next cycle rd(3)=0x11, rd(4)=0x22.
- Write collision: both ports to address 5, wd0=0xAAAA, wd1=0xBBBB -> rd(5)=0xBBBB.
- Zero register: write 0xFFFFFFFF to address 0 and set_busy addr 0 -> rd(0)=0, rbusy=0.
- Scoreboard: set_busy addr 9 -> rbusy(9)=1 next cycle; write 9 with set_busy 9 same edge -> stays 1; write 9 alone -> rbusy=0 next cycle.
- Bypass (REGFILE_BYPASS_EN): write 0x1234 to address 12, ra=12 same cycle -> rd=0x1234 combinationally; without macro -> old value, 0x1234 next cycle.
